// File: rtl/audio_clk_pkg.sv
// Shared definitions for the audio clock generator: channel state encoding,
// default counter width and named half-period divisors.
package audio_clk_pkg;

  // Default width of each half-period divisor and its counter.
  localparam int CNT_W_DEF = 24;

  // Named half-periods, in main_clock cycles, for a 50 MHz main_clock.
  // DIV_1HZ needs a counter at least 25 bits wide.
  localparam int DIV_1HZ       = 25_000_000;
  localparam int DIV_MCLK_12M5 = 2;
  localparam int DIV_BCLK      = 8;

  // Per-channel run state. STOPPING holds a high phase until its natural end
  // so a disable never produces a runt pulse.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } ch_state_e;

endpackage

// File: rtl/clk_div_channel.sv
// One divided-clock channel: run/stop FSM, half-period counter, divisor
// reload and edge-tick generation. All outputs come straight from flops.
module clk_div_channel
  import audio_clk_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 100
) (
  input  logic             main_clock,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  input  logic             ch_en,
  input  logic             sync_restart,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic             running
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             run_q, run_d;

  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] new_div;
  logic             wrap;
  logic             quiet_stop;

  // A zero divisor behaves as one so the channel never stalls.
  assign half    = (act_q == '0) ? ONE : act_q;
  assign wrap    = (cnt_q == (half - ONE));
  // Divisor that a reload point would pick up this cycle; a load in the same
  // cycle bypasses the pending register.
  assign new_div = div_load ? div_val : pend_q;
  // Disable while low: nothing to finish, drop straight to IDLE.
  assign quiet_stop = (state_q == ST_RUN) && !ch_en && !clk_q;

  // State register.
  always_ff @(posedge main_clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ch_en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (sync_restart)    state_d = ch_en ? ST_RUN : ST_IDLE;
        else if (!ch_en) begin
          // High phase: finish it in STOPPING unless it ends this cycle.
          if (!clk_q || wrap) state_d = ST_IDLE;
          else                state_d = ST_STOPPING;
        end
      end
      ST_STOPPING: begin
        if (sync_restart)    state_d = ST_IDLE;
        else if (wrap)       state_d = ch_en ? ST_RUN : ST_IDLE;
        else if (ch_en)      state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    cnt_d  = cnt_q;
    clk_d  = clk_q;
    act_d  = act_q;
    pend_d = new_div;
    rise_d = 1'b0;
    fall_d = 1'b0;
    run_d  = (state_d != ST_IDLE);
    if (state_q == ST_IDLE) begin
      // Idle loads take effect at once; the first half-period uses them.
      cnt_d = '0;
      clk_d = 1'b0;
      act_d = new_div;
    end else if (sync_restart) begin
      // Realign: restart the low phase, overriding any coincident wrap.
      cnt_d  = '0;
      clk_d  = 1'b0;
      fall_d = clk_q;
      act_d  = new_div;
    end else if (quiet_stop) begin
      cnt_d = '0;
      act_d = new_div;
    end else if (wrap) begin
      // Reload point: toggle, pulse the matching tick, adopt the divisor.
      cnt_d  = '0;
      clk_d  = !clk_q;
      rise_d = !clk_q;
      fall_d = clk_q;
      act_d  = new_div;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Datapath registers.
  always_ff @(posedge main_clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      act_q  <= DIV_RST;
      pend_q <= DIV_RST;
      clk_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      run_q  <= run_d;
    end
  end

  assign clk_out   = clk_q;
  assign rise_tick = rise_q;
  assign fall_tick = fall_q;
  assign running   = run_q;

endmodule

// File: rtl/audio_clk_gen.sv
// Multi-channel 50%-duty clock divider for codec MCLK/BCLK/LRCK and the
// display tick. Slices the packed divisor bus and fans out sync_restart.
module audio_clk_gen
  import audio_clk_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 100
) (
  input  logic                    main_clock,
  input  logic                    reset_n,
  input  logic [NUM_CH*CNT_W-1:0] div_in,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    sync_restart,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       rise_tick,
  output logic [NUM_CH-1:0]       fall_tick,
  output logic [NUM_CH-1:0]       running
);

  logic [NUM_CH-1:0][CNT_W-1:0] div_slice;

  // Channel k owns bits [k*CNT_W +: CNT_W].
  assign div_slice = div_in;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clk_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .main_clock   (main_clock),
      .reset_n      (reset_n),
      .div_val      (div_slice[k]),
      .div_load     (div_load[k]),
      .ch_en        (ch_en[k]),
      .sync_restart (sync_restart),
      .clk_out      (clk_out[k]),
      .rise_tick    (rise_tick[k]),
      .fall_tick    (fall_tick[k]),
      .running      (running[k])
    );
  end

endmodule

// File: tb/tb_audio_clk_gen.sv
// Directed plus randomized bench for audio_clk_gen with a countdown-based
// behavioural model checked every cycle.
module tb_audio_clk_gen;
  import audio_clk_pkg::*;

  localparam int NCH = 3;
  localparam int CW  = 24;
  localparam int DEF = 100;

  logic                main_clock = 1'b0;
  logic                reset_n;
  logic [NCH*CW-1:0]   div_in;
  logic [NCH-1:0]      div_load, ch_en;
  logic                sync_restart;
  logic [NCH-1:0]      clk_out, rise_tick, fall_tick, running;

  int checks = 0;
  int fails  = 0;

  // Model: per channel, whether it is running, level, cycles left in the
  // current half-period, pending divisor, and whether a disable is pending.
  int m_pend[NCH];
  int m_left[NCH];
  bit m_on[NCH], m_stop[NCH], m_lvl[NCH], m_rise[NCH], m_fall[NCH];

  always #5 main_clock = ~main_clock;

  audio_clk_gen #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DEF)) dut (
    .main_clock   (main_clock),
    .reset_n      (reset_n),
    .div_in       (div_in),
    .div_load     (div_load),
    .ch_en        (ch_en),
    .sync_restart (sync_restart),
    .clk_out      (clk_out),
    .rise_tick    (rise_tick),
    .fall_tick    (fall_tick),
    .running      (running)
  );

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_pend[k] = DEF; m_left[k] = 0;
      m_on[k] = 0; m_stop[k] = 0; m_lvl[k] = 0; m_rise[k] = 0; m_fall[k] = 0;
    end
  endtask

  // One main_clock edge worth of behaviour, from the inputs held this cycle.
  task automatic model_edge();
    for (int k = 0; k < NCH; k++) begin
      int din, newp;
      din  = int'(div_in[k*CW +: CW]);
      newp = div_load[k] ? din : m_pend[k];
      m_rise[k] = 0; m_fall[k] = 0; m_pend[k] = newp;
      if (!m_on[k]) begin
        m_lvl[k] = 0;
        if (ch_en[k]) begin m_on[k] = 1; m_stop[k] = 0; m_left[k] = eff(newp); end
      end else if (sync_restart) begin
        m_fall[k] = m_lvl[k]; m_lvl[k] = 0; m_left[k] = eff(newp);
        m_on[k] = ch_en[k] && !m_stop[k]; m_stop[k] = 0;
      end else if (!ch_en[k] && !m_lvl[k]) begin
        m_on[k] = 0;
      end else begin
        m_left[k] = m_left[k] - 1;
        if (m_left[k] == 0) begin
          m_lvl[k] = !m_lvl[k]; m_rise[k] = m_lvl[k]; m_fall[k] = !m_lvl[k];
          m_left[k] = eff(newp); m_on[k] = ch_en[k]; m_stop[k] = 0;
        end else begin
          m_stop[k] = !ch_en[k];
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [NCH-1:0] e_clk, e_rise, e_fall, e_run;
    for (int k = 0; k < NCH; k++) begin
      e_clk[k] = m_lvl[k]; e_rise[k] = m_rise[k]; e_fall[k] = m_fall[k]; e_run[k] = m_on[k];
    end
    checks++;
    assert (clk_out === e_clk) else begin
      fails++; $error("FAIL %s clk_out obs=%b exp=%b", tag, clk_out, e_clk);
    end
    checks++;
    assert (rise_tick === e_rise) else begin
      fails++; $error("FAIL %s rise_tick obs=%b exp=%b", tag, rise_tick, e_rise);
    end
    checks++;
    assert (fall_tick === e_fall) else begin
      fails++; $error("FAIL %s fall_tick obs=%b exp=%b", tag, fall_tick, e_fall);
    end
    checks++;
    assert (running === e_run) else begin
      fails++; $error("FAIL %s running obs=%b exp=%b", tag, running, e_run);
    end
  endtask

  task automatic expect_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++; $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle, update the model, check #1 after the edge.
  task automatic step();
    @(posedge main_clock);
    model_edge();
    #1;
    check_outputs("cycle");
  endtask

  // Steps until the chosen tick on channel k; n = steps taken, -1 on timeout.
  task automatic wait_tick(input int k, input bit want_rise, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if ((want_rise ? rise_tick[k] : fall_tick[k]) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic set_div(input int k, input int v);
    div_in[k*CW +: CW] = CW'(v);
  endtask

  initial begin
    int n, r0, r1;
    bit all_hi;
    reset_n = 1'b0; div_in = '0; div_load = '0; ch_en = '0; sync_restart = 1'b0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge main_clock);
    reset_n = 1'b1;
    repeat (2) step();

    // First edge latency and 50% duty at the default divisor.
    ch_en = 3'b001;
    wait_tick(0, 1'b1, 300, n); expect_int("first_rise", n, 101);
    wait_tick(0, 1'b0, 300, n); expect_int("high_time", n, 100);
    wait_tick(0, 1'b1, 300, n); expect_int("low_time", n, 100);

    // Mid-phase load of 4: current phase completes, then period 8.
    repeat (50) step();
    set_div(0, 4); div_load = 3'b001;
    step();
    div_load = '0;
    wait_tick(0, 1'b0, 200, n); expect_int("fall_after_load", n, 49);
    wait_tick(0, 1'b1, 20, n);  expect_int("div4_low", n, 4);
    wait_tick(0, 1'b0, 20, n);  expect_int("div4_high", n, 4);
    wait_tick(0, 1'b1, 20, n);  expect_int("div4_low2", n, 4);

    // Divisor 0 behaves as 1.
    set_div(0, 0); div_load = 3'b001;
    step();
    div_load = '0;
    wait_tick(0, 1'b0, 20, n); expect_int("div0_reload", n, 3);
    wait_tick(0, 1'b1, 5, n);  expect_int("div0_low", n, 1);
    wait_tick(0, 1'b0, 5, n);  expect_int("div0_high", n, 1);
    wait_tick(0, 1'b1, 5, n);  expect_int("div0_low2", n, 1);

    // Load coinciding with a wrap is used by that wrap.
    set_div(0, 6); div_load = 3'b001;
    step();
    div_load = '0;
    expect_int("bypass_fall", int'(fall_tick[0]), 1);
    wait_tick(0, 1'b1, 20, n); expect_int("bypass_half", n, 6);

    // Back to 100, then a clean stop from the high phase.
    set_div(0, DEF); div_load = 3'b001;
    step();
    div_load = '0;
    wait_tick(0, 1'b0, 20, n);  expect_int("div6_high", n, 5);
    wait_tick(0, 1'b1, 200, n); expect_int("div100_low", n, 100);
    repeat (30) step();
    ch_en = 3'b000;
    wait_tick(0, 1'b0, 200, n); expect_int("stop_fall", n, 70);
    expect_int("stop_running", int'(running[0]), 0);

    // Re-enabling during STOPPING leaves the waveform untouched.
    ch_en = 3'b001;
    wait_tick(0, 1'b1, 300, n); expect_int("restart_rise", n, 101);
    repeat (30) step();
    ch_en = 3'b000;
    repeat (20) step();
    expect_int("stopping_running", int'(running[0]), 1);
    ch_en = 3'b001;
    wait_tick(0, 1'b0, 200, n); expect_int("reenable_fall", n, 50);
    expect_int("reenable_running", int'(running[0]), 1);
    wait_tick(0, 1'b1, 200, n); expect_int("reenable_low", n, 100);

    // Stop channel 0, then run three channels out of phase and realign.
    ch_en = 3'b000;
    wait_tick(0, 1'b0, 200, n); expect_int("stop_again", n, 100);
    set_div(0, DIV_MCLK_12M5); set_div(1, DIV_BCLK); set_div(2, 6);
    div_load = 3'b111;
    step();
    div_load = '0;
    ch_en = 3'b001; repeat (3) step();
    ch_en = 3'b011; repeat (5) step();
    ch_en = 3'b111; repeat (7) step();
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    expect_int("sync_low", int'(clk_out[1:0]), 0);
    r0 = -1; r1 = -1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (rise_tick[0] === 1'b1 && r0 < 0) r0 = i;
      if (rise_tick[1] === 1'b1 && r1 < 0) r1 = i;
    end
    expect_int("sync_rise0", r0, 2);
    expect_int("sync_rise1", r1, 8);

    // Asynchronous reset in the middle of a common high phase.
    all_hi = 1'b0;
    for (int i = 0; i < 80 && !all_hi; i++) begin
      step();
      all_hi = (clk_out === 3'b111);
    end
    expect_int("all_high_seen", int'(all_hi), 1);
    #2 reset_n = 1'b0;
    #1;
    expect_int("rst_clk", int'(clk_out), 0);
    expect_int("rst_rise", int'(rise_tick), 0);
    expect_int("rst_fall", int'(fall_tick), 0);
    expect_int("rst_running", int'(running), 0);
    model_reset();
    ch_en = '0;
    @(negedge main_clock);
    reset_n = 1'b1;
    repeat (2) step();
    ch_en = 3'b001;
    wait_tick(0, 1'b1, 300, n); expect_int("rst_default_div", n, 101);

    // Randomized traffic with small divisors, checked against the model.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NCH; k++) begin
        set_div(k, int'($urandom_range(0, 9)));
        div_load[k] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 15) == 0) ch_en[k] = ~ch_en[k];
      end
      sync_restart = ($urandom_range(0, 39) == 0);
      step();
    end
    div_load = '0; sync_restart = 1'b0;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
